// File: rtl/norm_pkg.sv
// Shared types and helpers for the sequential normalisers.
package norm_pkg;

   typedef enum logic [1:0] {
      IDLE  = 2'd0,
      SHIFT = 2'd1,
      DONE  = 2'd2
   } norm_state_t;

   // Signed shift-count width: wide enough for +/-(width-1)
   function automatic int cnt_width(input int width);
      return $clog2(width) + 1;
   endfunction

   // Leading zeros of the low `step` bits of win, scanning from bit step-1
   // downwards; returns step when those bits are all zero.
   function automatic int unsigned lz_window(input logic [63:0] win,
                                             input int unsigned step);
      int unsigned n;
      logic        found;
      logic [63:0] tmp;
      n     = 0;
      found = 1'b0;
      for (int unsigned i = 0; i < step; i++) begin
         tmp = win >> (step - 1 - i);
         if (!found) begin
            if (tmp[0]) found = 1'b1;
            else        n++;
         end
      end
      return n;
   endfunction

endpackage

// File: rtl/lzc_window.sv
// Combinational leading-zero count over a STEP-bit slice (0..STEP).
module lzc_window
   import norm_pkg::*;
#(
   parameter  int STEP = 1,
   localparam int KW   = $clog2(STEP + 1)
) (
   input  logic [STEP-1:0] win,
   output logic [KW-1:0]   k
);

   // Count zeros from the top of the slice down to the first one
   always_comb begin
      k = KW'(lz_window(64'(win), STEP));
   end

endmodule

// File: rtl/norm_shift_seq.sv
// Sequential normaliser: moves the leading one of an operand to MSB_POS,
// left by up to STEP bits per cycle, right by one bit per cycle.
module norm_shift_seq
   import norm_pkg::*;
#(
   parameter  int WIDTH   = 32,
   parameter  int MSB_POS = 23,
   parameter  int STEP    = 1,
   localparam int CNT_W   = cnt_width(WIDTH)
) (
   input  logic             clk,
   input  logic             rst,
   input  logic             in_valid,
   output logic             in_ready,
   input  logic [WIDTH-1:0] a,
   output logic             out_valid,
   input  logic             out_ready,
   output logic [WIDTH-1:0] x,
   output logic [CNT_W-1:0] s,
   output logic             zero
);

   localparam int KW = $clog2(STEP + 1);

   norm_state_t      state;
   logic [KW-1:0]    k;
   logic             above;
   logic [WIDTH-1:0] x_shl;

   lzc_window #(
      .STEP(STEP)
   ) u_lzc (
      .win(x[MSB_POS -: STEP]),
      .k  (k)
   );

   // Overflow detection and the left-shifted candidate for this cycle
   always_comb begin
      above = |(x >> (MSB_POS + 1));
      x_shl = x << k;
   end

   // Handshake FSM and shift datapath with registered outputs
   always_ff @(posedge clk) begin
      if (rst) begin
         state     <= IDLE;
         x         <= '0;
         s         <= '0;
         zero      <= 1'b0;
         out_valid <= 1'b0;
         in_ready  <= 1'b1;
      end else begin
         case (state)
            IDLE: begin
               if (in_valid) begin
                  x        <= a;
                  s        <= '0;
                  zero     <= 1'b0;
                  in_ready <= 1'b0;
                  state    <= SHIFT;
               end
            end
            SHIFT: begin
               if (x == '0) begin
                  zero      <= 1'b1;
                  out_valid <= 1'b1;
                  state     <= DONE;
               end else if (above) begin
                  x <= x >> 1;
                  s <= s - CNT_W'(1);
               end else if (x[MSB_POS]) begin
                  out_valid <= 1'b1;
                  state     <= DONE;
               end else begin
                  x <= x_shl;
                  s <= s + CNT_W'(k);
               end
            end
            DONE: begin
               if (out_ready) begin
                  out_valid <= 1'b0;
                  in_ready  <= 1'b1;
                  state     <= IDLE;
               end
            end
            default: begin
               out_valid <= 1'b0;
               in_ready  <= 1'b1;
               state     <= IDLE;
            end
         endcase
      end
   end

endmodule

// File: tb/tb_norm_shift_seq.sv
// Bench for norm_shift_seq: STEP=1 and STEP=4 instances share stimulus and
// are checked every cycle against a transaction-level model.
module tb_norm_shift_seq;

   localparam int W  = 32;
   localparam int MP = 23;
   localparam int CW = 6;

   logic          clk = 1'b0;
   logic          rst;
   logic          in_valid;
   logic [W-1:0]  a;
   logic          out_ready;
   logic [1:0]    in_ready;
   logic [1:0]    out_valid;
   logic [1:0]    zero;
   logic [W-1:0]  xo [2];
   logic [CW-1:0] so [2];

   int n_vec = 0;
   int n_err = 0;

   always #5 clk = ~clk;

   norm_shift_seq #(.WIDTH(W), .MSB_POS(MP), .STEP(1)) dut0 (
      .clk(clk), .rst(rst), .in_valid(in_valid), .in_ready(in_ready[0]),
      .a(a), .out_valid(out_valid[0]), .out_ready(out_ready),
      .x(xo[0]), .s(so[0]), .zero(zero[0])
   );

   norm_shift_seq #(.WIDTH(W), .MSB_POS(MP), .STEP(4)) dut1 (
      .clk(clk), .rst(rst), .in_valid(in_valid), .in_ready(in_ready[1]),
      .a(a), .out_valid(out_valid[1]), .out_ready(out_ready),
      .x(xo[1]), .s(so[1]), .zero(zero[1])
   );

   task automatic chk(input string nm, input longint act, input longint exp);
      n_vec++;
      if (act != exp) begin
         n_err++;
         $display("FAIL %s: got %0d (0x%0h) expected %0d (0x%0h) at %0t",
                  nm, act, act, exp, exp, $time);
      end
   endtask

   // Result and latency from the normalisation rules, by leading-one position
   function automatic void model(input logic [W-1:0] av, input int step,
                                 output logic [W-1:0] mx, output int ms,
                                 output bit mz, output int ml);
      int p;
      p = -1;
      for (int i = 0; i < W; i++) if (av[i]) p = i;
      mz = 1'b0;
      if (p < 0) begin
         mx = '0; ms = 0; mz = 1'b1; ml = 2;
      end else if (p > MP) begin
         mx = av >> (p - MP); ms = -(p - MP); ml = 2 + (p - MP);
      end else begin
         mx = av << (MP - p); ms = MP - p; ml = 2 + (MP - p + step - 1) / step;
      end
   endfunction

   int          steps [2] = '{1, 4};
   bit          busy  [2] = '{1'b0, 1'b0};
   int          acc   [2] = '{0, 0};
   int          lat   [2] = '{0, 0};
   logic [W-1:0] ex   [2] = '{'0, '0};
   int          es    [2] = '{0, 0};
   bit          ez    [2] = '{1'b0, 1'b0};
   int          cyc = 0;
   bit          mon_en = 1'b0;

   // Model: track accept, expected result and release per instance
   always @(posedge clk) begin
      cyc++;
      for (int d = 0; d < 2; d++) begin
         if (rst) begin
            busy[d] = 1'b0; ex[d] = '0; es[d] = 0; ez[d] = 1'b0;
         end else if (busy[d]) begin
            if ((cyc - 1 >= acc[d] + lat[d] - 1) && out_ready) busy[d] = 1'b0;
         end else if (in_valid) begin
            busy[d] = 1'b1;
            acc[d]  = cyc;
            model(a, steps[d], ex[d], es[d], ez[d], lat[d]);
         end
      end
   end

   // Compare every cycle on the falling edge
   always @(negedge clk) begin
      if (mon_en) begin
         for (int d = 0; d < 2; d++) begin
            bit ev;
            ev = busy[d] && (cyc >= acc[d] + lat[d] - 1);
            chk($sformatf("dut%0d.in_ready", d), longint'(in_ready[d]), longint'(!busy[d]));
            chk($sformatf("dut%0d.out_valid", d), longint'(out_valid[d]), longint'(ev));
            if (!busy[d] || ev) begin
               chk($sformatf("dut%0d.x", d), longint'(xo[d]), longint'(ex[d]));
               chk($sformatf("dut%0d.s", d), longint'($signed(so[d])), longint'(es[d]));
               chk($sformatf("dut%0d.zero", d), longint'(zero[d]), longint'(ez[d]));
            end
         end
      end
   end

   // One operand through both instances, checked against literal values
   task automatic run_vec(input logic [W-1:0] av, input logic [W-1:0] lx,
                          input int ls, input bit lz, input int l1, input int l4);
      bit seen [2];
      int lt [2];
      seen = '{1'b0, 1'b0};
      lt   = '{l1, l4};
      @(posedge clk); #1;
      a = av; in_valid = 1'b1;
      @(posedge clk); #1;
      in_valid = 1'b0;
      for (int k = 1; k <= 60 && !(seen[0] && seen[1]); k++) begin
         @(negedge clk);
         for (int d = 0; d < 2; d++) begin
            if (out_valid[d] && !seen[d]) begin
               seen[d] = 1'b1;
               chk($sformatf("lit%0d.lat a=%0h", d, av), longint'(k), longint'(lt[d]));
               chk($sformatf("lit%0d.x a=%0h", d, av), longint'(xo[d]), longint'(lx));
               chk($sformatf("lit%0d.s a=%0h", d, av), longint'($signed(so[d])), longint'(ls));
               chk($sformatf("lit%0d.zero a=%0h", d, av), longint'(zero[d]), longint'(lz));
            end
         end
      end
      for (int d = 0; d < 2; d++)
         if (!seen[d]) chk($sformatf("timeout%0d a=%0h", d, av), 0, 1);
   endtask

   initial begin
      logic [W-1:0] mx;
      int ms, ml;
      bit mz;

      // Pin the model itself on hand-computed cases
      model(32'h0000_0001, 1, mx, ms, mz, ml);
      chk("model.x a=1", longint'(mx), 64'h0080_0000);
      chk("model.lat a=1 step1", longint'(ml), 25);
      model(32'h0000_0001, 4, mx, ms, mz, ml);
      chk("model.lat a=1 step4", longint'(ml), 8);
      model(32'h8000_0000, 4, mx, ms, mz, ml);
      chk("model.s a=80000000", longint'(ms), -8);

      rst = 1'b1; in_valid = 1'b0; a = '0; out_ready = 1'b1;
      repeat (2) @(posedge clk);
      #1 rst = 1'b0;
      mon_en = 1'b1;
      @(negedge clk);
      for (int d = 0; d < 2; d++) begin
         chk($sformatf("reset%0d.in_ready", d), longint'(in_ready[d]), 1);
         chk($sformatf("reset%0d.out_valid", d), longint'(out_valid[d]), 0);
         chk($sformatf("reset%0d.x", d), longint'(xo[d]), 0);
      end

      //       a              x              s   z  lat1 lat4
      run_vec(32'h0000_0001, 32'h0080_0000, 23, 0, 25, 8);
      run_vec(32'h0400_0000, 32'h0080_0000, -3, 0, 5, 5);
      run_vec(32'h8000_0000, 32'h0080_0000, -8, 0, 10, 10);
      run_vec(32'h0000_0000, 32'h0000_0000, 0, 1, 2, 2);
      run_vec(32'h00C0_0000, 32'h00C0_0000, 0, 0, 2, 2);
      run_vec(32'h0008_0000, 32'h0080_0000, 4, 0, 6, 3);
      run_vec(32'h0000_0003, 32'h00C0_0000, 22, 0, 24, 8);
      run_vec(32'hFFFF_FFFF, 32'h00FF_FFFF, -8, 0, 10, 10);
      run_vec(32'h0000_0100, 32'h0080_0000, 15, 0, 17, 6);

      // Back-pressure: hold DONE, ignore a new operand, then release
      @(posedge clk); #1;
      out_ready = 1'b0;
      a = 32'h0040_0000; in_valid = 1'b1;
      @(posedge clk); #1;
      in_valid = 1'b0;
      a = 32'h1234_5678;
      repeat (4) @(posedge clk);
      #1 a = 32'h0000_0001; in_valid = 1'b1;
      @(posedge clk); #1 in_valid = 1'b0;
      repeat (8) @(posedge clk);
      #1 out_ready = 1'b1; in_valid = 1'b1; a = 32'h0000_0002;
      @(posedge clk); #1 in_valid = 1'b0;
      repeat (2) @(posedge clk);

      // Reset in the middle of a long left shift
      #1 a = 32'h0000_0001; in_valid = 1'b1;
      @(posedge clk); #1 in_valid = 1'b0;
      repeat (5) @(posedge clk);
      #1 rst = 1'b1;
      @(posedge clk); #1 rst = 1'b0;
      @(negedge clk);
      for (int d = 0; d < 2; d++) begin
         chk($sformatf("midrst%0d.out_valid", d), longint'(out_valid[d]), 0);
         chk($sformatf("midrst%0d.s", d), longint'($signed(so[d])), 0);
         chk($sformatf("midrst%0d.x", d), longint'(xo[d]), 0);
      end
      run_vec(32'h0040_0000, 32'h0080_0000, 1, 0, 3, 3);

      repeat (3) @(posedge clk);
      @(negedge clk);
      $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
      $finish;
   end

   initial begin
      #200000;
      $display("FAIL watchdog: simulation did not finish, got timeout expected completion");
      $fatal(1, "watchdog");
   end

endmodule

// File: doc/norm_shift_seq.md
# norm_shift_seq

Parametrised sequential normaliser for the ALU integer-to-float path. It accepts a WIDTH-bit operand over a valid/ready handshake and shifts it until the leading one sits at bit MSB_POS. Left normalisation advances up to STEP bits per cycle; right normalisation of overflow bits advances one bit per cycle. It returns the normalised word, a signed shift count, and a zero flag for downstream exponent adjustment.

## Interface
- WIDTH, 32, operand/result width
- MSB_POS, 23, target bit index of the leading one (0 < MSB_POS < WIDTH)
- STEP, 1, maximum left-shift bits per cycle (1..MSB_POS)
- CNT_W, $clog2(WIDTH)+1, signed shift-count width (derived, not overridden)

- clk  in  1  clock, rising edge
- rst  in  1  synchronous, active-high reset
- in_valid  in  1  operand a is valid
- in_ready  out  1  block can accept an operand (high only in IDLE)
- a  in  WIDTH  operand
- out_valid  out  1  result valid (high only in DONE)
- out_ready  in  1  consumer takes result
- x  out  WIDTH  normalised word
- s  out  CNT_W  signed shift count: +n = n left shifts, −m = m right shifts
- zero  out  1  operand was all zeros

## Operation
- States: IDLE, SHIFT, DONE.
- IDLE:
  - in_ready=1.
  - On in_valid, load x←a, s←0, zero←0, and go to SHIFT.
- SHIFT, evaluated on x each cycle:
  - x==0: set zero←1 and go to DONE. s stays 0.
  - Any bit above MSB_POS set: x←x>>1 (logical), s←s−1, stay in SHIFT.
  - x[MSB_POS]==1 and no bits above it: go to DONE with no shift.
  - Otherwise, let k = leading zeros of the window x[MSB_POS : MSB_POS−STEP+1], where k=STEP if the window is all zero. Then x←x<<k, s←s+k, stay in SHIFT.
- DONE:
  - out_valid=1; x, s and zero are held stable.
  - On out_ready, go to IDLE. The next operand is not accepted in that same cycle.
- Bits shifted out are discarded and never reported.
- s never exceeds +MSB_POS or goes below −(WIDTH−1−MSB_POS), so it cannot overflow CNT_W.
- a is sampled only at acceptance. Later changes to a have no effect until the next accept.

## Timing
- Reset values: state=IDLE, x=0, s=0, zero=0, out_valid=0, in_ready=1 in the cycle after rst.
- rst asserted in any state, including mid-SHIFT or DONE, aborts the operation. The partial result is dropped and nothing is emitted.
- Accept in cycle t. Then out_valid rises at:
  - t+2 when the operand is already normalised or zero.
  - t+2+⌈n/STEP⌉ for a left shift of n.
  - t+2+m for a right shift of m.
- out_valid holds for as long as out_ready is low. Back-pressure adds exactly its own duration to the latency.
- in_valid and out_ready have no effect outside IDLE and DONE respectively.
- All outputs are registered; there is no combinational path from inputs to outputs.

## Structure
- Package norm_pkg holds:
  - the state enum (IDLE, SHIFT, DONE);
  - the CNT_W derivation function;
  - a leading-zero-in-window function, also used by future normalisers.
- One sub-module, lzc_window: combinational leading-zero count over a STEP-bit slice, returning k in 0..STEP. The FSM and datapath stay in norm_shift_seq.

## Test plan
Unless stated otherwise: WIDTH=32, MSB_POS=23, out_ready=1.
- STEP=1, a=0x00000001 → x=0x00800000, s=+23, zero=0; out_valid 25 cycles after accept.
- STEP=4, a=0x00000001 → x=0x00800000, s=+23; out_valid 8 cycles after accept (shifts of 4,4,4,4,4,3).
- a=0x04000000 → x=0x00800000, s=−3; out_valid 5 cycles after accept. Also a=0x80000000 → s=−8, x=0x00800000.
- a=0 → zero=1, s=0, x=0; out_valid 2 cycles after accept. Also a=0x00C00000 → s=0, x unchanged, 2 cycles.
- Back-pressure: hold out_ready=0 for 10 cycles in DONE → x, s and zero stable, in_ready=0, and a new in_valid pulse is ignored. Release → IDLE next cycle.
- Pulse rst during SHIFT for a=0x00000001 → next cycle IDLE, x=0, s=0, out_valid=0. A new a=0x00400000 then yields s=+1 with normal latency.
